// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: register-file constants shared by the register file and its write queue
package regfile_write_queue_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    typedef enum logic [1:0] {Q_EMPTY, Q_PARTIAL, Q_NEARFULL} q_state_e;
    // NEARFULL means fewer than two free slots, so a dual write could not fit
    function automatic q_state_e q_state(input int cnt, input int depth);
        return cnt == 0 ? Q_EMPTY : (depth - cnt < 2 ? Q_NEARFULL : Q_PARTIAL);
    endfunction
endpackage

// File: rtl/regfile_write_queue_fwd_match.sv
// wq_fwd_match: finds the youngest valid queue entry whose destination matches a read index
// Ports: addr_i/data_i/vld_i entry array, rd_ptr_i head index, rr_i read index,
//        hit_o match found (never for register 0), data_o youngest matching data or 0
module wq_fwd_match
    import regfile_write_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr_i [DEPTH],
    input  logic [DATA_W-1:0] data_i [DEPTH],
    input  logic [DEPTH-1:0]  vld_i,
    input  logic [PW-1:0]     rd_ptr_i,
    input  logic [ADDR_W-1:0] rr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);
    logic [PW-1:0] idx;
    // walk from head (oldest) toward tail so later matches override earlier ones
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PW'(k);
            if (rr_i != '0 && vld_i[idx] && addr_i[idx] == rr_i) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: buffers ALU/load result writes and drains one per cycle into the register file
// Ports: alu_*/mem_* write requests, in_ready room for two writes, rf_* register file write port,
//        fwd_rr*/fwd_hit*/fwd_data* read bypass of pending writes, count occupancy,
//        err_overflow sticky request-while-not-ready flag
module regfile_write_queue #(
    parameter int DATA_W = regfile_write_queue_pkg::DATA_W,
    parameter int ADDR_W = regfile_write_queue_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_wr,
    input  logic [DATA_W-1:0] alu_wd,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_wr,
    input  logic [DATA_W-1:0] mem_wd,
    output logic              in_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    input  logic [ADDR_W-1:0] fwd_rr1,
    input  logic [ADDR_W-1:0] fwd_rr2,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [CW-1:0]     count,
    output logic              err_overflow
);
    import regfile_write_queue_pkg::*;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot_a;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              push_m, push_a, pop;
    assign in_ready = q_state(int'(count_q), DEPTH) != Q_NEARFULL;
    assign push_m   = in_ready && mem_valid && mem_wr != '0;
    assign push_a   = in_ready && alu_valid && alu_wr != '0;
    assign pop      = count_q != '0;
    // the load is the older instruction, so it takes the first free slot
    assign slot_a   = wr_ptr_q + PW'(push_m);
    assign wr_ptr_d = slot_a + PW'(push_a);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign count_d  = count_q + CW'(push_m) + CW'(push_a) - CW'(pop);
    assign err_d    = err_q || (!in_ready && (mem_valid || alu_valid));
    // pushes never target the head slot while it is popped, so set-after-clear is safe
    always_comb begin
        vld_d = vld_q;
        if (pop) vld_d[rd_ptr_q] = 1'b0;
        if (push_m) vld_d[wr_ptr_q] = 1'b1;
        if (push_a) vld_d[slot_a] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_m) begin
            addr_q[wr_ptr_q] <= mem_wr;
            data_q[wr_ptr_q] <= mem_wd;
        end
        if (push_a) begin
            addr_q[slot_a] <= alu_wr;
            data_q[slot_a] <= alu_wd;
        end
    end
    assign rf_we        = pop;
    assign rf_wr        = pop ? addr_q[rd_ptr_q] : '0;
    assign rf_wd        = pop ? data_q[rd_ptr_q] : '0;
    assign count        = count_q;
    assign err_overflow = err_q;
    wq_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd1 (
        .addr_i(addr_q), .data_i(data_q), .vld_i(vld_q), .rd_ptr_i(rd_ptr_q),
        .rr_i(fwd_rr1), .hit_o(fwd_hit1), .data_o(fwd_data1)
    );
    wq_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd2 (
        .addr_i(addr_q), .data_i(data_q), .vld_i(vld_q), .rd_ptr_i(rd_ptr_q),
        .rr_i(fwd_rr2), .hit_o(fwd_hit2), .data_o(fwd_data2)
    );
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end for the 32x32 register file: buffers result writes from the ALU and load (memory) paths, then drains them one per cycle into the register file's single write port (wd / wr / Re).
- Provides read-side bypass so a reader sees queued writes that have not yet reached the register file.
- Sits between the execute/memory stages and the register file in the phase 2 datapath.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- DEPTH, 4, queue entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result write request
- alu_wr  in  ADDR_W  ALU destination register
- alu_wd  in  DATA_W  ALU result
- mem_valid  in  1  load result write request
- mem_wr  in  ADDR_W  load destination register
- mem_wd  in  DATA_W  load data
- in_ready  out  1  queue can accept two writes this cycle
- rf_we  out  1  drives register file Re
- rf_wr  out  ADDR_W  drives register file wr
- rf_wd  out  DATA_W  drives register file wd
- fwd_rr1  in  ADDR_W  read index 1 (mirrors rr1)
- fwd_rr2  in  ADDR_W  read index 2 (mirrors rr2)
- fwd_hit1  out  1  pending write exists for fwd_rr1
- fwd_data1  out  DATA_W  youngest pending data for fwd_rr1
- fwd_hit2  out  1  same for fwd_rr2
- fwd_data2  out  DATA_W  same for fwd_rr2
- count  out  $clog2(DEPTH+1)  occupied entries
- err_overflow  out  1  sticky: request arrived while in_ready low

Behaviour:
- Storage: circular buffer with wr_ptr/rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH) plus an occupancy counter.
- Reset (async, rst_n low): pointers, count and err_overflow go to 0; all entry valid bits clear. In the same instant rf_we=0, fwd_hit1=0, fwd_hit2=0 and in_ready=1. Data contents are don't-care.
- Reset mid-operation: queued writes are discarded. They never reach the register file.
- in_ready = (DEPTH - count) >= 2. This is combinational from registered state only.
- Enqueue at a rising edge, only when in_ready=1:
  - Requests with destination 0 are dropped and not counted.
  - If both requests are valid and nonzero, the mem entry is written first (older instruction), then the alu entry. Up to 2 entries are added per cycle.
- Requests while in_ready=0 are ignored and set err_overflow=1, which holds until reset. Upstream must stall on in_ready.
- Drain (combinational from the head entry):
  - When count>0: rf_we=1, rf_wr=head addr, rf_wd=head data.
  - When count==0: rf_we=0; rf_wr and rf_wd are 0.
  - The head is popped at every rising edge where count>0.
- Latency: a write accepted at edge N appears on rf_* during cycle N..N+1 (when the queue is empty) and is committed by the register file in that cycle.
- Simultaneous push and pop: count_next = count + pushes - pop. Full and empty transitions are handled in the same edge without loss.
- Forwarding:
  - Combinational search of all valid entries, the head included.
  - fwd_hitX=1 iff fwd_rrX != 0 and some entry matches.
  - fwd_dataX = data of the youngest matching entry (closest to wr_ptr).
  - On a miss, fwd_dataX = 0.
- No FSM beyond the pointer/counter state. The queue state is one of EMPTY (count 0), PARTIAL, or NEARFULL (in_ready=0), all derived from count.

Decomposition:
- Shared include (regfile_defs): DATA_W=32, ADDR_W=5, NUM_REGS=32, REG_ZERO=0. The register file and this block both use it.
- One sub-module: wq_fwd_match. It takes the entry array, valid mask, pointer and read index, and returns hit plus youngest data. It is instantiated twice (rr1, rr2).

Test Plan:
- Reset then idle -> rf_we=0, count=0, in_ready=1, err_overflow=0; assert rst_n low while count=3 -> count=0 and rf_we=0 immediately.
- Single ALU write: alu_wr=5, alu_wd=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_wr=5, rf_wd=0xDEADBEEF; following cycle rf_we=0; register 5 reads 0xDEADBEEF.
- Dual write in one cycle: mem_wr=3/0x11, alu_wr=7/0x22 -> rf sees reg 3 then reg 7 on consecutive cycles; count goes 2,1,0.
- Zero register: alu_wr=0, alu_wd=0xFFFFFFFF -> not enqueued, count stays 0, rf_we never asserts.
- Forwarding youngest: enqueue reg 9=0xA, then reg 9=0xB while head is stalled behind an earlier entry; fwd_rr1=9 -> fwd_hit1=1, fwd_data1=0xB; fwd_rr2=0 -> fwd_hit2=0.
- Fill to count=3 (DEPTH=4) -> in_ready=0; drive alu_valid -> request ignored, err_overflow=1 and stays 1; queue drains in order with pointers wrapping past entry 3 to 0 with no data loss.
